// File: rtl/pipeline_dump_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_dump_unit
//  Purpose  : Snapshots pipeline registers, memory, PC and a cycle stamp, then
//             streams them as a framed, XOR-checksummed byte sequence.
//  Revision : 1.0
// ============================================================================
module pipeline_dump_unit #(
   parameter int          NREG   = 32,
   parameter int          NMEM   = 10,
   parameter int          PCW    = 10,
   parameter logic [7:0]  HEADER = 8'hA5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [NREG*32-1:0]  Registers,
   input  logic [NMEM*32-1:0]  Memorias,
   input  logic [PCW-1:0]      PC,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                busy,
   output logic                done
);

   localparam int                FRAME_LEN = 7 + 4*NREG + 4*NMEM + 1;
   localparam int                IDXW      = $clog2(FRAME_LEN);
   localparam logic [IDXW-1:0]   LAST_IDX  = IDXW'(FRAME_LEN - 1);
   localparam int                REG_BASE  = 7;
   localparam int                MEM_BASE  = 7 + 4*NREG;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } stateT;

   stateT               r_state;
   logic [31:0]         r_cycleCnt;
   logic [31:0]         r_shadowCnt;
   logic [PCW-1:0]      r_shadowPc;
   logic [NREG*32-1:0]  r_shadowRegs;
   logic [NMEM*32-1:0]  r_shadowMem;
   logic [IDXW-1:0]     r_byteIdx;
   logic [7:0]          r_checksum;
   logic                r_txValid;
   logic                r_busy;
   logic                r_done;

   logic [15:0]         w_pcExt;
   logic [7:0]          w_frameBytes [FRAME_LEN];
   logic                w_xfer;

   assign w_pcExt = 16'(r_shadowPc);
   assign w_xfer  = r_txValid & tx_ready;

   // Frame layout: header, cycle stamp, PC, registers, memory, then the running checksum.
   assign w_frameBytes[0]             = HEADER;
   assign w_frameBytes[1]             = r_shadowCnt[31:24];
   assign w_frameBytes[2]             = r_shadowCnt[23:16];
   assign w_frameBytes[3]             = r_shadowCnt[15:8];
   assign w_frameBytes[4]             = r_shadowCnt[7:0];
   assign w_frameBytes[5]             = w_pcExt[15:8];
   assign w_frameBytes[6]             = w_pcExt[7:0];
   assign w_frameBytes[FRAME_LEN-1]   = r_checksum;

   generate
      for (genvar i = 0; i < NREG; i++) begin : g_regs
         for (genvar b = 0; b < 4; b++) begin : g_regBytes
            assign w_frameBytes[REG_BASE + 4*i + b] = r_shadowRegs[32*i + 8*(3-b) +: 8];
         end
      end
      for (genvar i = 0; i < NMEM; i++) begin : g_mem
         for (genvar b = 0; b < 4; b++) begin : g_memBytes
            assign w_frameBytes[MEM_BASE + 4*i + b] = r_shadowMem[32*i + 8*(3-b) +: 8];
         end
      end
   endgenerate

   assign tx_data  = r_txValid ? w_frameBytes[r_byteIdx] : 8'h00;
   assign tx_valid = r_txValid;
   assign busy     = r_busy;
   assign done     = r_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cycleCnt <= 32'd0;
      end else begin
         r_cycleCnt <= r_cycleCnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_shadowCnt  <= 32'd0;
         r_shadowPc   <= '0;
         r_shadowRegs <= '0;
         r_shadowMem  <= '0;
         r_byteIdx    <= '0;
         r_checksum   <= 8'h00;
         r_txValid    <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  // Counter value before this edge's increment is the stamp.
                  r_shadowCnt  <= r_cycleCnt;
                  r_shadowPc   <= PC;
                  r_shadowRegs <= Registers;
                  r_shadowMem  <= Memorias;
                  r_byteIdx    <= '0;
                  r_checksum   <= 8'h00;
                  r_txValid    <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= SEND;
               end
            end
            SEND: begin
               if (w_xfer) begin
                  r_checksum <= r_checksum ^ tx_data;
                  if (r_byteIdx == LAST_IDX) begin
                     r_txValid <= 1'b0;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_state   <= DONE;
                  end else begin
                     r_byteIdx <= r_byteIdx + 1'b1;
                  end
               end
            end
            DONE: begin
               r_done    <= 1'b0;
               r_byteIdx <= '0;
               r_state   <= IDLE;
            end
            default: begin
               r_txValid <= 1'b0;
               r_busy    <= 1'b0;
               r_done    <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/pipeline_dump_unit.md
# pipeline_dump_unit

Debug-dump stage sitting directly downstream of the five-stage `Pipeline`. It consumes the pipeline's flattened register-file (`Registers`) and data-memory (`Memorias`) buses plus the current PC, and takes an atomic snapshot on request. It then serialises the snapshot as a framed, checksummed byte stream over a valid/ready byte interface, which feeds the board UART transmitter. It also keeps a free-running cycle counter so each dump is time-stamped.

## Interface
- `NREG`, 32, number of 32-bit registers in `Registers`
- `NMEM`, 10, number of 32-bit words in `Memorias`
- `PCW`, 10, PC width
- `HEADER`, 8'hA5, frame start byte

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; one clock, reset asserted when low
- `start`  in  1  dump request; sampled only in IDLE
- `Registers`  in  NREG*32  register i = bits [32i+31:32i]
- `Memorias`  in  NMEM*32  word i = bits [32i+31:32i]
- `PC`  in  PCW  current PC (`PC_IFID`)
- `tx_data`  out  8  stream byte
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  sink accepts byte
- `busy`  out  1  high from snapshot until frame fully sent
- `done`  out  1  one-cycle pulse after the last byte is accepted

## Operation
- Cycle counter: 32-bit, cleared by reset, +1 every `clk` edge, wraps 0xFFFFFFFF→0.
- States: IDLE → SEND → DONE → IDLE.
- IDLE with `start`=1 at an edge: latch `Registers`, `Memorias`, `PC` and the cycle counter value present before that edge's increment into shadow registers. Clear byte index and checksum, go to SEND.
- Frame, 176 bytes, multi-byte fields MSB first:
  - byte 0: `HEADER`
  - bytes 1–4: cycle count
  - bytes 5–6: PC zero-extended to 16 bits
  - bytes 7–134: registers 0..31
  - bytes 135–174: memory words 0..9
  - byte 175: checksum = XOR of bytes 0–174
- SEND: `tx_data` is a combinational mux of shadow data by byte index. A transfer occurs on an edge where `tx_valid` and `tx_ready` are both 1. On each transfer, index +1 and checksum ^= byte. When byte 175 transfers, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE. Input changes after the snapshot edge do not affect the frame.
- Reset: async low forces IDLE, `tx_valid`=0, `busy`=0, `done`=0, `tx_data`=0, index=0, checksum=0, counter=0. Reset mid-frame abandons the frame with no `done`. Reset wins over a simultaneous `start`.

## Timing
- `busy` and `tx_valid` rise the cycle after the `start` edge. Byte 0 is presented that same cycle.
- `tx_valid` stays high continuously through SEND. `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0, and never changes without a transfer.
- With `tx_ready` held 1, the frame takes 176 consecutive cycles. `done` pulses on the cycle after byte 175's transfer edge; `busy` falls in that same cycle.
- `start` held high continuously causes a new snapshot on the first edge after DONE, giving 1 idle cycle between frames.
- `tx_data` is 0 when `tx_valid`=0.

## Test plan
- Reset/idle: hold `reset` low, then release with `start`=0 for 20 cycles → `tx_valid`=0, `busy`=0, `done`=0 throughout.
- Basic frame: set reg1=0x11223344, mem9=0xDEADBEEF, PC=10'h3FF, others 0, `tx_ready`=1, pulse `start` → 176 consecutive bytes. Byte0=0xA5; bytes 5–6=0x03,0xFF; bytes 11–14=0x11,0x22,0x33,0x44; bytes 171–174=0xDE,0xAD,0xBE,0xEF; byte175 = XOR of bytes 0–174; `done` pulses once.
- Backpressure: drop `tx_ready` for 5 cycles at byte 50 → `tx_data` holds byte 50, no byte lost or duplicated, frame ends 5 cycles later.
- Snapshot integrity: change reg1 to 0xFFFFFFFF one cycle after `start` → bytes 11–14 still 0x11,0x22,0x33,0x44.
- Counter: `start` when counter=0x0000012C → bytes 1–4 = 0x00,0x00,0x01,0x2C. Separately force wrap from 0xFFFFFFFF → next dump shows a small count.
- Mid-frame reset: assert `reset` at byte 90 → `tx_valid`/`busy` drop immediately, no `done`. A subsequent `start` yields a fresh, complete 176-byte frame.
